// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and defaults for the two-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2, ABORT = 2'd3} state_t;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: counts stalled strobe cycles and flags expiry on the TIMEOUT-th one
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic stb,
  input  logic ack,
  output logic expire
);
  localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (!reset || !en || !stb || ack) cnt <= '0;
    else if (cnt != W'(TIMEOUT)) cnt <= cnt + 1'b1;
  // the current stalled cycle counts, so expiry fires while the register holds TIMEOUT-1
  assign expire = (TIMEOUT != 0) && en && stb && !ack && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m: round-robin two-master to one-slave Wishbone arbiter with abort watchdog
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_cyc,
  input  logic          m0_stb,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [DW-1:0] m0_dat_w,
  output logic [DW-1:0] m0_dat_r,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_cyc,
  input  logic          m1_stb,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m1_dat_w,
  output logic [DW-1:0] m1_dat_r,
  output logic          m1_ack,
  output logic          m1_err,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  input  logic [DW-1:0] s_dat_r,
  input  logic          s_ack,
  output logic [1:0]    gnt
);
  state_t state, state_d;
  logic own, own_d, act, c, expire;
  wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .reset(reset), .en(act), .stb(s_stb), .ack(s_ack), .expire(expire)
  );
  // own is the current owner while granted and the last owner once idle
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      own   <= 1'b1;
    end else begin
      state <= state_d;
      own   <= own_d;
    end
  always_comb begin
    act      = state == GRANT0 || state == GRANT1;
    c        = own ? m1_cyc : m0_cyc;
    s_cyc    = act && c;
    s_stb    = act && (own ? m1_stb : m0_stb);
    s_we     = act && (own ? m1_we : m0_we);
    s_adr    = act ? (own ? m1_adr : m0_adr) : '0;
    s_dat_w  = act ? (own ? m1_dat_w : m0_dat_w) : '0;
    m0_ack   = act && !own && s_ack;
    m1_ack   = act && own && s_ack;
    m0_err   = act && !own && expire;
    m1_err   = act && own && expire;
    gnt      = state == IDLE ? 2'b00 : {own, !own};
    m0_dat_r = s_dat_r;
    m1_dat_r = s_dat_r;
    own_d    = own;
    state_d  = state;
    case (state)
      IDLE:
        if (m0_cyc || m1_cyc) begin
          own_d   = !(m0_cyc && (!m1_cyc || own));
          state_d = own_d ? GRANT1 : GRANT0;
        end
      GRANT0, GRANT1: state_d = !c ? IDLE : expire ? ABORT : state;
      default: state_d = c ? ABORT : IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb_wb_arbiter_2m: scoreboard bench for wb_arbiter_2m with a one-cycle-ack slave model
module tb_wb_arbiter_2m;
  typedef struct packed {
    logic        err;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [1:0]  gnt;
  } ev_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [1:0] m_cyc = '0, m_stb = '0, m_we = '0, m_ack, m_err;
  logic [31:0] m_adr[2], m_dat_w[2], dr0, dr1;
  logic s_cyc, s_stb, s_we, s_ack;
  logic ack_r = 1'b0, late_ack = 1'b0, slv_en = 1'b1;
  logic [31:0] s_adr, s_dat_w, s_dat_r;
  logic [1:0] gnt, prev_gnt = '0;
  ev_t q0[$], q1[$];
  logic [1:0] gq[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m_cyc[0]), .m0_stb(m_stb[0]), .m0_we(m_we[0]), .m0_adr(m_adr[0]),
    .m0_dat_w(m_dat_w[0]), .m0_dat_r(dr0), .m0_ack(m_ack[0]), .m0_err(m_err[0]),
    .m1_cyc(m_cyc[1]), .m1_stb(m_stb[1]), .m1_we(m_we[1]), .m1_adr(m_adr[1]),
    .m1_dat_w(m_dat_w[1]), .m1_dat_r(dr1), .m1_ack(m_ack[1]), .m1_err(m_err[1]),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_dat_w(s_dat_w),
    .s_dat_r(s_dat_r), .s_ack(s_ack), .gnt(gnt)
  );

  // slave: read data is the inverted address, ack one cycle after each strobe
  assign s_dat_r = ~s_adr;
  assign s_ack   = ack_r | late_ack;
  always @(posedge clk) ack_r <= slv_en && s_stb && !ack_r;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++)
      if (m_ack[m] || m_err[m]) begin
        ev_t e;
        if ((m == 0 && q0.size() == 0) || (m == 1 && q1.size() == 0)) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp m%0d: got ack=%b err=%b want none", m, m_ack[m], m_err[m]);
        end else begin
          if (m == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("resp_err", 32'(m_err[m]), 32'(e.err));
          chk("resp_adr", s_adr, e.adr);
          chk("resp_gnt", 32'(gnt), 32'(e.gnt));
          if (!e.err) chk("resp_dat", e.we ? s_dat_w : (m == 0 ? dr0 : dr1), e.dat);
        end
      end
    if (gnt != prev_gnt && gnt != 2'b00) begin
      logic [1:0] g;
      chk("grant_gap", 32'(prev_gnt), 32'd0);
      if (gq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant: got %b want none", gnt);
      end else begin
        g = gq.pop_front();
        chk("grant_order", 32'(gnt), 32'(g));
      end
    end
    prev_gnt <= gnt;
  end

  task automatic mcyc(input int m, input logic we, input logic [31:0] adr, input int beats,
                      input logic [31:0] wd, input bit lat);
    ev_t e;
    int n;
    @(posedge clk);
    #1;
    m_cyc[m] = 1'b1;
    m_we[m]  = we;
    for (int b = 0; b < beats; b++) begin
      m_adr[m]   = adr + 32'(4 * b);
      m_dat_w[m] = wd + 32'(b);
      m_stb[m]   = 1'b1;
      e.err = 1'b0;
      e.we  = we;
      e.adr = m_adr[m];
      e.dat = we ? m_dat_w[m] : ~m_adr[m];
      e.gnt = m == 0 ? 2'b01 : 2'b10;
      if (m == 0) q0.push_back(e);
      else q1.push_back(e);
      if (lat && b == 0) begin
        @(negedge clk);
        chk("lat_idle", 32'(s_cyc), 32'd0);
        @(negedge clk);
        chk("lat_scyc", 32'(s_cyc), 32'd1);
        chk("lat_adr", s_adr, adr);
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!m_ack[m] && n < 40);
      if (n >= 40) begin
        tests++;
        fails++;
        $display("FAIL ack_timeout m%0d: got no ack want ack", m);
      end
      @(posedge clk);
      #1;
      m_stb[m] = 1'b0;
    end
    m_cyc[m] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    ev_t e;
    int n, k;
    m_adr[0] = '0; m_adr[1] = '0; m_dat_w[0] = '0; m_dat_w[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_sctl", 32'({s_cyc, s_stb, s_we}), 32'd0);
    chk("rst_sadr", s_adr, 32'd0);
    chk("rst_resp", 32'({m_ack, m_err}), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    // single master write
    gq.push_back(2'b01);
    mcyc(0, 1'b1, 32'h10, 1, 32'hA5A5A5A5, 1'b1);
    // tie straight out of reset
    pulse_reset();
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      mcyc(0, 1'b0, 32'h40, 1, 32'h0, 1'b0);
      mcyc(1, 1'b0, 32'h50, 1, 32'h0, 1'b0);
    join
    // fairness under continuous requests
    repeat (3) begin gq.push_back(2'b01); gq.push_back(2'b10); end
    fork
      for (int i = 0; i < 3; i++) mcyc(0, 1'b1, 32'h1000 + 32'(16 * i), 1, 32'h100 + 32'(i), 1'b0);
      for (int i = 0; i < 3; i++) mcyc(1, 1'b1, 32'h2000 + 32'(16 * i), 1, 32'h200 + 32'(i), 1'b0);
    join
    // hold-off during a 4-beat read
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      mcyc(0, 1'b0, 32'h100, 4, 32'h0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        mcyc(1, 1'b0, 32'h200, 1, 32'h0, 1'b0);
      end
    join
    // watchdog abort on a silent slave
    slv_en = 1'b0;
    gq.push_back(2'b10);
    e.err = 1'b1; e.we = 1'b0; e.adr = 32'h300; e.dat = '0; e.gnt = 2'b10;
    q1.push_back(e);
    @(posedge clk);
    #1;
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_adr[1] = 32'h300;
    n = 0; k = 0;
    do begin
      @(negedge clk);
      k++;
      if (s_stb) n++;
    end while (!m_err[1] && k < 20);
    chk("to_stb_cycles", 32'(n), 32'd4);
    @(negedge clk);
    chk("abort_scyc", 32'(s_cyc), 32'd0);
    chk("abort_gnt", 32'(gnt), 32'd2);
    @(posedge clk);
    #1;
    m_stb[1] = 1'b0;
    late_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_hold", 32'(gnt), 32'd2);
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    m_cyc[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_exit", 32'(gnt), 32'd0);
    // reset in the middle of a GRANT0 transfer
    gq.push_back(2'b01);
    @(posedge clk);
    #1;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b0; m_adr[0] = 32'h400;
    repeat (2) @(negedge clk);
    chk("mid_gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    slv_en = 1'b1;
    @(negedge clk);
    chk("mr_sctl", 32'({s_cyc, s_stb}), 32'd0);
    chk("mr_gnt", 32'(gnt), 32'd0);
    chk("mr_resp", 32'({m_ack, m_err}), 32'd0);
    gq.push_back(2'b01); gq.push_back(2'b10);
    fork
      mcyc(0, 1'b1, 32'h500, 1, 32'h11, 1'b0);
      mcyc(1, 1'b1, 32'h600, 1, 32'h22, 1'b0);
    join
    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("gq_drained", 32'(gq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
